// File: rtl/change_monitor.sv
// change_monitor
//   Watches NCH channels of WIDTH bits each. After the first enabled sample
//   (arming), every enabled cycle in which a channel differs from its previous
//   sample is a "change": the channel's saturating counter increments, and
//   the lowest-indexed changed channel of that cycle is pushed into a small
//   event FIFO. Extra simultaneous changes, and pushes into a full FIFO, are
//   reported through the sticky ev_ovf flag.
//
//   Optional build macro: CHANGE_MONITOR_CLEAR_ON_READ_EN
//     When defined, a counter read clears the selected counter at the same
//     edge that captures rd_cnt. If that channel changes in the same cycle,
//     the counter becomes 1. When undefined, reads are non-destructive.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   din      : NCH*WIDTH sample bus, channel i at [i*WIDTH +: WIDTH]
//   en       : sample enable
//   rd_req   : counter read request (one-cycle latency)
//   rd_sel   : channel to read; out-of-range selects return 0
//   rd_ack   : high for the one cycle after an rd_req edge
//   rd_cnt   : counter value captured at the request edge
//   ev_valid : event FIFO non-empty
//   ev_ready : consumer accepts the head entry
//   ev_ch    : head entry channel index
//   ev_val   : head entry sampled value
//   ev_ovf   : sticky event-loss flag
//   ovf_clr  : clears ev_ovf (a loss in the same cycle wins)
//
// Handshake: an entry transfers on a rising edge where ev_valid && ev_ready.
// While ev_valid is high and ev_ready is low, ev_ch/ev_val hold steady.
module change_monitor #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4,
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 en,
  input  logic                 rd_req,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic                 rd_ack,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [SEL_W-1:0]     ev_ch,
  output logic [WIDTH-1:0]     ev_val,
  output logic                 ev_ovf,
  input  logic                 ovf_clr
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  logic [WIDTH-1:0]       prev [NCH];
  logic [CNT_W-1:0]       cnt  [NCH];
  logic                   armed;

  logic [NCH-1:0]         changed;
  logic [SEL_W-1:0]       low_idx;
  logic [WIDTH-1:0]       low_val;
  logic                   multi;

  logic [SEL_W+WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [FCNT_W-1:0]      fcount;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   push_ok;
  logic                   loss;

  // Change detection and lowest-index priority pick.
  always_comb begin
    changed = '0;
    low_idx = '0;
    low_val = '0;
    for (int i = 0; i < NCH; i++) begin
      changed[i] = en && armed && (din[i*WIDTH +: WIDTH] != prev[i]);
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (changed[i]) begin
        low_idx = SEL_W'(i);
        low_val = din[i*WIDTH +: WIDTH];
      end
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi    = |(changed & (changed - NCH'(1)));

  assign ev_valid = (fcount != '0);
  assign full     = (fcount == FCNT_W'(DEPTH));
  assign push     = |changed;
  assign pop      = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok  = push && (!full || pop);
  assign loss     = multi || (push && full && !pop);

  // Head outputs are forced to zero when empty so reset/empty reads as 0.
  assign ev_ch    = ev_valid ? mem[rd_ptr][SEL_W+WIDTH-1:WIDTH] : '0;
  assign ev_val   = ev_valid ? mem[rd_ptr][WIDTH-1:0] : '0;

  // Sample history and arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
      for (int i = 0; i < NCH; i++) prev[i] <= '0;
    end else if (en) begin
      armed <= 1'b1;
      for (int i = 0; i < NCH; i++) prev[i] <= din[i*WIDTH +: WIDTH];
    end
  end

  // Per-channel saturating change counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
`ifdef CHANGE_MONITOR_CLEAR_ON_READ_EN
        if (rd_req && (int'(rd_sel) == i)) begin
          cnt[i] <= changed[i] ? CNT_W'(1) : '0;
        end else
`endif
        if (changed[i] && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Counter read port: one-cycle registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ack <= 1'b0;
      rd_cnt <= '0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req && (int'(rd_sel) < NCH)) rd_cnt <= cnt[rd_sel];
      else                                rd_cnt <= '0;
    end
  end

  // Event FIFO storage (contents need no reset; visibility is gated by count).
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= {low_idx, low_val};
  end

  // Event FIFO pointers, occupancy and sticky loss flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
      ev_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fcount <= fcount + FCNT_W'(1);
        2'b01:   fcount <= fcount - FCNT_W'(1);
        default: fcount <= fcount;
      endcase
      if (loss)         ev_ovf <= 1'b1;
      else if (ovf_clr) ev_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_change_monitor.sv
// tb_change_monitor
//   Directed bench for change_monitor with NCH=5 (so rd_sel can address a
//   non-existent channel), WIDTH=8, CNT_W=4 (so saturation is reachable) and
//   DEPTH=4. Inputs change one time unit after a rising edge; outputs are
//   checked at that same point, well away from the next edge.
module tb_change_monitor;

  localparam int NCH   = 5;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int DEPTH = 4;
  localparam int SEL_W = 3;

`ifdef CHANGE_MONITOR_CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NCH*WIDTH-1:0] din = '0;
  logic                 en = 1'b0;
  logic                 rd_req = 1'b0;
  logic [SEL_W-1:0]     rd_sel = '0;
  logic                 rd_ack;
  logic [CNT_W-1:0]     rd_cnt;
  logic                 ev_valid;
  logic                 ev_ready = 1'b0;
  logic [SEL_W-1:0]     ev_ch;
  logic [WIDTH-1:0]     ev_val;
  logic                 ev_ovf;
  logic                 ovf_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  change_monitor #(.NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_cnt(rd_cnt),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ch(ev_ch), .ev_val(ev_val),
    .ev_ovf(ev_ovf), .ovf_clr(ovf_clr)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] v);
    din[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_cnt(input string tag, input int ch, input logic [31:0] exp);
    check({tag, "_idle_ack"}, 32'(rd_ack), 32'd0);
    rd_req = 1'b1;
    rd_sel = SEL_W'(ch);
    tick();
    rd_req = 1'b0;
    check({tag, "_ack"}, 32'(rd_ack), 32'd1);
    check({tag, "_cnt"}, 32'(rd_cnt), exp);
    tick();
    check({tag, "_ack_drop"}, 32'(rd_ack), 32'd0);
  endtask

  task automatic pop_ev(input string tag, input int ch, input logic [31:0] v);
    check({tag, "_valid"}, 32'(ev_valid), 32'd1);
    check({tag, "_ch"}, 32'(ev_ch), 32'(ch));
    check({tag, "_val"}, 32'(ev_val), v);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  initial begin
    // ---- Reset state ----
    rst = 1'b1;
    tick();
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_ack", 32'(rd_ack), 32'd0);
    check("rst_cnt", 32'(rd_cnt), 32'd0);
    check("rst_ovf", 32'(ev_ovf), 32'd0);
    check("rst_ch", 32'(ev_ch), 32'd0);
    check("rst_val", 32'(ev_val), 32'd0);
    rst = 1'b0;

    // ---- Single channel sequence 00,00,05,05,07 ----
    en = 1'b1;
    set_ch(0, 8'h00); tick();
    check("arm_no_event", 32'(ev_valid), 32'd0);
    set_ch(0, 8'h00); tick();
    set_ch(0, 8'h05); tick();
    set_ch(0, 8'h05); tick();
    set_ch(0, 8'h07); tick();
    en = 1'b0;
    set_ch(0, 8'hAA);  // ignored while en=0
    tick();
    set_ch(0, 8'h07);
    read_cnt("seq_cnt0", 0, 32'd2);
    pop_ev("seq_ev0", 0, 32'h05);
    pop_ev("seq_ev1", 0, 32'h07);
    check("seq_empty", 32'(ev_valid), 32'd0);
    check("seq_no_ovf", 32'(ev_ovf), 32'd0);

    // ---- Simultaneous changes on ch1 and ch3 ----
    en = 1'b1;
    set_ch(1, 8'h11); set_ch(3, 8'h33);
    tick();
    en = 1'b0;
    check("multi_ovf", 32'(ev_ovf), 32'd1);
    read_cnt("multi_cnt1", 1, 32'd1);
    read_cnt("multi_cnt3", 3, 32'd1);
    read_cnt("multi_cnt2", 2, 32'd0);
    pop_ev("multi_ev", 1, 32'h11);
    check("multi_one_entry", 32'(ev_valid), 32'd0);
    check("multi_ovf_sticky", 32'(ev_ovf), 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ev_ovf), 32'd0);

    // Clear coinciding with a new loss keeps the flag set.
    en = 1'b1; ovf_clr = 1'b1;
    set_ch(1, 8'h12); set_ch(2, 8'h22);
    tick();
    en = 1'b0; ovf_clr = 1'b0;
    check("clr_vs_loss", 32'(ev_ovf), 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared2", 32'(ev_ovf), 32'd0);
    pop_ev("clr_vs_loss_ev", 1, 32'h12);

    // ---- FIFO full, drop, and pop+push while full ----
    rst = 1'b1; tick(); rst = 1'b0;
    din = '0; en = 1'b1; tick();  // arm
    for (int k = 1; k <= DEPTH + 1; k++) begin
      set_ch(0, 8'(k)); tick();
    end
    en = 1'b0;
    check("full_ovf", 32'(ev_ovf), 32'd1);
    check("full_head_val", 32'(ev_val), 32'h01);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("full_ovf_clr", 32'(ev_ovf), 32'd0);
    en = 1'b1; ev_ready = 1'b1; set_ch(0, 8'h06);
    tick();
    en = 1'b0; ev_ready = 1'b0;
    check("full_popush_no_loss", 32'(ev_ovf), 32'd0);
    pop_ev("full_e0", 0, 32'h02);
    pop_ev("full_e1", 0, 32'h03);
    pop_ev("full_e2", 0, 32'h04);
    pop_ev("full_e3", 0, 32'h06);
    check("full_drained", 32'(ev_valid), 32'd0);

    // ---- Counter saturation (CNT_W=4) and out-of-range select ----
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      set_ch(2, 8'(k)); tick();
    end
    en = 1'b0;
    read_cnt("sat_cnt2", 2, 32'd15);
    read_cnt("oor_sel", 6, 32'd0);

    // ---- Clear-on-read behaviour ----
    rst = 1'b1; tick(); rst = 1'b0;
    din = '0; en = 1'b1; tick();  // arm
    set_ch(0, 8'h01); tick();
    set_ch(0, 8'h02); tick();
    set_ch(0, 8'h03); tick();
    en = 1'b0;
    rd_req = 1'b1; rd_sel = '0;
    tick();
    check("cor_first_ack", 32'(rd_ack), 32'd1);
    check("cor_first", 32'(rd_cnt), 32'd3);
    tick();
    check("cor_reread_ack", 32'(rd_ack), 32'd1);
    check("cor_reread", 32'(rd_cnt), CLR ? 32'd0 : 32'd3);
    // Read coinciding with a change on the same channel.
    en = 1'b1; set_ch(0, 8'h04);
    tick();
    en = 1'b0; rd_req = 1'b0;
    check("cor_race_read", 32'(rd_cnt), CLR ? 32'd0 : 32'd3);
    tick();
    read_cnt("cor_race_reread", 0, CLR ? 32'd1 : 32'd4);

    // ---- Mid-stream reset with queued events and a pending read ----
    check("mid_has_events", 32'(ev_valid), 32'd1);
    rst = 1'b1; rd_req = 1'b1;
    tick();
    check("mid_rst_valid", 32'(ev_valid), 32'd0);
    check("mid_rst_ack", 32'(rd_ack), 32'd0);
    check("mid_rst_ch", 32'(ev_ch), 32'd0);
    check("mid_rst_val", 32'(ev_val), 32'd0);
    tick();
    check("mid_rst_hold_ack", 32'(rd_ack), 32'd0);
    rst = 1'b0; rd_req = 1'b0;
    tick();
    for (int c = 0; c < NCH; c++) read_cnt("mid_zero", c, 32'd0);
    en = 1'b1; set_ch(0, 8'h55);
    tick();
    en = 1'b0;
    check("mid_rearm_no_ev", 32'(ev_valid), 32'd0);
    read_cnt("mid_rearm_cnt", 0, 32'd0);
    en = 1'b1; set_ch(0, 8'h56);
    tick();
    en = 1'b0;
    pop_ev("mid_after_arm", 0, 32'h56);
    read_cnt("mid_after_cnt", 0, 32'd1);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
